// File: rtl/sar_sm_pkg.sv
// ---------------------------------------------------------------------------
// sar_sm_pkg : shared types for the sign-magnitude SAR search engine
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sar_sm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SIGN = 2'd1,
    S_MAG  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sar_sm_search.sv
// ---------------------------------------------------------------------------
// sar_sm_search : recovers an N-bit sign-magnitude target through GE queries
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sar_sm_search
  import sar_sm_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic [N-1:0] o_trial,
  output logic         o_trial_valid,
  input  logic         i_cmp,
  input  logic         i_cmp_valid
);

  localparam int M  = N - 1;
  localparam int KW = (M > 1) ? $clog2(M) : 1;

  state_t          r_state;
  logic [M-1:0]    r_mag;
  logic [KW-1:0]   r_k;
  logic            r_neg;
  logic [N-1:0]    r_result;

  logic            w_accept;
  logic [M-1:0]    w_bit;
  logic            w_set;
  logic [M-1:0]    w_mag_next;

  assign o_trial_valid = (r_state == S_SIGN) || (r_state == S_MAG);
  assign o_busy        = o_trial_valid;
  assign o_done        = (r_state == S_DONE);
  assign o_result      = r_result;
  assign w_accept      = o_trial_valid & i_cmp_valid;
  assign w_bit         = M'(1) << r_k;

  // A negative target ranks below a negative trial exactly when its modulus is larger.
  assign w_set      = r_neg ? ~i_cmp : i_cmp;
  assign w_mag_next = w_set ? (r_mag | w_bit) : r_mag;

  always_comb begin
    o_trial = '0;
    if (r_state == S_MAG) begin
      if (r_neg == SIGN_NEG) o_trial = {SIGN_NEG, r_mag | (w_bit - M'(1))};
      else                   o_trial = {SIGN_POS, r_mag | w_bit};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_mag    <= '0;
      r_k      <= '0;
      r_neg    <= SIGN_POS;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mag   <= '0;
            r_k     <= KW'(M - 1);
            r_neg   <= SIGN_POS;
            r_state <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (w_accept) begin
            r_neg   <= i_cmp ? SIGN_POS : SIGN_NEG;
            r_state <= S_MAG;
          end
        end
        S_MAG: begin
          if (w_accept) begin
            r_mag <= w_mag_next;
            if (r_k == '0) begin
              r_result <= {r_neg, w_mag_next};
              r_state  <= S_DONE;
            end else begin
              r_k <= r_k - KW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sar_sm_search.sv
// ---------------------------------------------------------------------------
// tb_sar_sm_search : self-checking bench with a latency-programmable responder
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cmp_responder #(
  parameter int N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [3:0]   i_lat,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_trial_valid,
  output logic         o_cmp,
  output logic         o_cmp_valid
);

  logic [3:0] r_cnt;

  // Map sign-magnitude onto integers so that -0 sits just below +0.
  function automatic int smkey(input logic [N-1:0] v);
    int m;
    m = int'(v[N-2:0]);
    return v[N-1] ? (-m - 1) : m;
  endfunction

  assign o_cmp       = (smkey(i_a) >= smkey(i_b));
  assign o_cmp_valid = i_trial_valid && (r_cnt >= i_lat);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                     r_cnt <= '0;
    else if (!i_trial_valid || o_cmp_valid)        r_cnt <= '0;
    else if (r_cnt != 4'hF)                        r_cnt <= r_cnt + 4'd1;
  end

endmodule

module tb_sar_sm_search;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_start = 1'b0;
  logic         o_busy, o_done, o_trial_valid, w_cmp, w_cmp_valid;
  logic [N-1:0] o_result, o_trial;
  logic [N-1:0] r_tgt = '0;
  logic [3:0]   r_lat = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int stab_err = 0;
  int busy_err = 0;
  int done_cnt = 0;
  int cyc;
  logic         pend = 1'b0;
  logic [N-1:0] prev = '0;
  logic [N-1:0] tq[$];
  logic [N-1:0] eq[$];

  typedef struct {
    logic [7:0] target;
    int         lat;
    logic [7:0] exp_result;
    int         exp_done;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  sar_sm_search #(.N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start),
    .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_trial(o_trial), .o_trial_valid(o_trial_valid),
    .i_cmp(w_cmp), .i_cmp_valid(w_cmp_valid)
  );

  cmp_responder #(.N(N)) u_resp (
    .i_clk(clk), .i_rst(rst), .i_lat(r_lat), .i_a(r_tgt), .i_b(o_trial),
    .i_trial_valid(o_trial_valid), .o_cmp(w_cmp), .o_cmp_valid(w_cmp_valid)
  );

  // Record every answered trial and watch trial stability while waiting.
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_trial_valid) begin
      if (pend && (o_trial != prev)) stab_err++;
      prev = o_trial;
      pend = !w_cmp_valid;
      if (w_cmp_valid) tq.push_back(o_trial);
    end else begin
      pend = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: binary search over the modulus, one sign probe first.
  task automatic model_trials(input logic [7:0] tgt);
    int m, hi, t;
    m = int'(tgt[6:0]);
    eq.delete();
    eq.push_back(8'h00);
    for (int k = 6; k >= 0; k--) begin
      hi = (m >> (k + 1)) << (k + 1);
      t  = tgt[7] ? (128 + hi + (1 << k) - 1) : (hi + (1 << k));
      eq.push_back(8'(t));
    end
  endtask

  task automatic chk_trials(input string name);
    int bad;
    bad = (tq.size() != eq.size()) ? 1 : 0;
    for (int i = 0; i < tq.size() && i < eq.size(); i++)
      if (tq[i] != eq[i] && bad == 0) begin
        bad = 1;
        $display("FAIL %s: trial[%0d] got 0x%0h, expected 0x%0h", name, i, tq[i], eq[i]);
      end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL %s: %0d trials seen, expected %0d", name, tq.size(), eq.size());
    end
  endtask

  task automatic run_search(input logic [7:0] tgt, input int lat, input int pulse_at);
    r_tgt = tgt;
    r_lat = 4'(lat);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    tq.delete();
    stab_err = 0;
    busy_err = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (o_done || cyc >= 300) break;
      if (!o_busy) busy_err++;
      i_start = (cyc == pulse_at);
      @(posedge clk);
      cyc++;
    end
    i_start = 1'b0;
    if (cyc >= 300) chk("timeout", cyc, 0);
  endtask

  task automatic run_and_check(input string name, input logic [7:0] tgt, input int lat,
                               input int pulse_at);
    run_search(tgt, lat, pulse_at);
    model_trials(tgt);
    chk({name, "_result"}, int'(o_result), int'(tgt));
    chk({name, "_done_cycle"}, cyc, 8 * (lat + 1));
    chk({name, "_busy"}, busy_err + int'(o_busy), 0);
    chk({name, "_stable"}, stab_err, 0);
    chk_trials({name, "_trials"});
  endtask

  initial begin
    vecs[0] = '{8'h5D, 0, 8'h5D, 8};
    vecs[1] = '{8'h85, 0, 8'h85, 8};
    vecs[2] = '{8'h00, 0, 8'h00, 8};
    vecs[3] = '{8'h80, 0, 8'h80, 8};
    vecs[4] = '{8'h7F, 0, 8'h7F, 8};
    vecs[5] = '{8'hFF, 0, 8'hFF, 8};
    vecs[6] = '{8'h2A, 3, 8'h2A, 32};

    repeat (2) @(negedge clk);
    chk("reset_outputs", int'({o_busy, o_done, o_result, o_trial, o_trial_valid}), 0);
    rst = 1'b0;

    run_search(8'h5D, 0, -1);
    eq = '{8'h00, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5E, 8'h5D};
    chk_trials("pos93_fixed_trials");
    run_search(8'h85, 0, -1);
    eq = '{8'h00, 8'hBF, 8'h9F, 8'h8F, 8'h87, 8'h83, 8'h85, 8'h84};
    chk_trials("neg5_fixed_trials");

    for (int i = 0; i < 7; i++) begin
      run_search(vecs[i].target, vecs[i].lat, -1);
      chk($sformatf("vec%0d_result", i), int'(o_result), int'(vecs[i].exp_result));
      chk($sformatf("vec%0d_done_cycle", i), cyc, vecs[i].exp_done);
      chk($sformatf("vec%0d_answers", i), tq.size(), 8);
      chk($sformatf("vec%0d_stable", i), stab_err, 0);
    end

    for (int i = 0; i < 16; i++)
      run_and_check($sformatf("rand%0d", i), 8'($urandom_range(0, 255)),
                    int'($urandom_range(0, 2)), -1);

    // Start mid-search must not disturb the sequence; start in S_DONE is dropped.
    run_and_check("start_busy", 8'h63, 1, 5);
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("start_in_done_ignored", int'({o_busy, o_done}), 0);
    i_start = 1'b0;
    run_and_check("start_after_done", 8'h9A, 0, -1);

    // Asynchronous abort between edges.
    r_tgt = 8'h3C;
    r_lat = 4'd1;
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (7) @(posedge clk);
    cyc = done_cnt;
    #2 rst = 1'b1;
    #1 chk("abort_outputs", int'({o_busy, o_done, o_result, o_trial, o_trial_valid}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - cyc, 0);
    chk("abort_idle", int'(o_busy), 0);
    run_and_check("after_abort", 8'hC0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
